// File: rtl/lfsr_seq.sv
// rtl/lfsr_seq.sv - seeded LFSR sequence engine with step count, mode select and abort
//
// Purpose:
//   On a start request in IDLE, captures a seed, a step count and a stepping
//   mode. It then advances an LFSR that many steps, publishes the final state
//   on num and pulses done for one cycle. A zero step count publishes the
//   (fixed) seed directly.
//
// Parameters:
//   WIDTH  - LFSR / seed / result width in bits (>= 3)
//   CNT_W  - width of the step counter / seq_num
//   TAPS   - tap mask, WIDTH bits (default x^8+x^6+x^5+x^4+1)
//
// Ports:
//   clk      in   1      system clock, rising edge
//   rst_n    in   1      asynchronous active-low reset
//   start    in   1      run request, sampled only in IDLE
//   abort    in   1      cancel current run, sampled only in RUN
//   mode     in   1      0 = Fibonacci, 1 = Galois; captured at start
//   sw_in    in   WIDTH  seed; captured at start
//   seq_num  in   CNT_W  number of steps; captured at start
//   num      out  WIDTH  result of the last completed run
//   busy     out  1      high while stepping
//   done     out  1      one-cycle pulse when num updates

module lfsr_seq #(
    parameter int unsigned      WIDTH = 8,
    parameter int unsigned      CNT_W = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [WIDTH-1:0] sw_in,
    input  logic [CNT_W-1:0] seq_num,
    output logic [WIDTH-1:0] num,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] SEED_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q,  lfsr_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             mode_q,  mode_d;
    logic [WIDTH-1:0] num_q,   num_d;

    logic [WIDTH-1:0] seed_fixed;
    logic [WIDTH-1:0] lfsr_next;

    // Shift left, feedback bit is the parity of the tapped bits.
    function automatic logic [WIDTH-1:0] fib_step(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], ^(v & TAPS)};
    endfunction

    // Shift right, XOR the tap mask in whenever a one falls off the end.
    function automatic logic [WIDTH-1:0] galois_step(input logic [WIDTH-1:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : {WIDTH{1'b0}});
    endfunction

    // An all-zero state is a fixed point of both step functions, so it is
    // never allowed into the register as a seed.
    assign seed_fixed = (sw_in == {WIDTH{1'b0}}) ? SEED_ONE : sw_in;

    // Mode is the captured copy, so changes on the mode pin mid-run are inert.
    assign lfsr_next = mode_q ? galois_step(lfsr_q) : fib_step(lfsr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lfsr_q  <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            mode_q  <= 1'b0;
            num_q   <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            num_q   <= num_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        num_d   = num_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lfsr_d = seed_fixed;
                    cnt_d  = seq_num;
                    mode_d = mode;
                    // A zero-length run completes without ever entering RUN,
                    // which also keeps the counter from wrapping below zero.
                    if (seq_num == {CNT_W{1'b0}}) begin
                        num_d   = seed_fixed;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                // Abort wins over completion, even on the final step.
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    lfsr_d = lfsr_next;
                    cnt_d  = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        num_d   = lfsr_next;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign num  = num_q;
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

endmodule

// File: doc/lfsr_seq.md
Name: lfsr_seq

Overview:
Parametrised pseudo-random sequence engine for the LFSR project. On a start request it loads a seed, advances an LFSR a programmed number of steps, presents the final state on num and pulses done. Width, tap polynomial and step-counter width are parameters. Fibonacci or Galois stepping is selected per run, and a run can be aborted. It feeds the switch/display top level and the pseudo-random testbenches.

Parameters:
WIDTH, 8, LFSR/seed/num width in bits (>=3)
CNT_W, 8, width of seq_num step counter
TAPS, 8'hB8, tap mask of WIDTH bits (default x^8+x^6+x^5+x^4+1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  run request, level-sampled only in IDLE
abort  in  1  cancel current run, sampled only in RUN
mode  in  1  0 = Fibonacci step, 1 = Galois step; captured at start
sw_in  in  WIDTH  seed value; captured at start
seq_num  in  CNT_W  number of LFSR steps; captured at start
num  out  WIDTH  result of last completed run
busy  out  1  high while stepping (state RUN)
done  out  1  one-cycle pulse when num updates

Behaviour:
- Reset (rst_n low, async): state=IDLE, lfsr=0, cnt=0, mode_r=0, num=0, busy=0, done=0. A reset mid-run discards the run with no done pulse.
- Seed fix: a captured seed of all zeros is replaced with 1 (lock-up avoidance).
- Fibonacci step: lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}.
- Galois step: lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0).
- FSM states: IDLE, RUN, DONE. busy = (state==RUN). done = (state==DONE).
- IDLE, start=1 at an edge: load lfsr<=fixed seed, cnt<=seq_num, mode_r<=mode.
  - If seq_num==0: num<=fixed seed and go to DONE. busy never rises.
  - Otherwise go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each edge: lfsr<=step(lfsr), cnt<=cnt-1.
  - When cnt==1 at that edge: num<=step(lfsr) and go to DONE.
  - With seq_num=N, busy is high exactly N cycles, and done follows in the next cycle.
- RUN with abort=1: go to IDLE. No step is taken, num is unchanged and done is not pulsed. abort has priority over completion.
- DONE: lasts one cycle, then go to IDLE. start is ignored in DONE, so back-to-back runs need start still high in the following IDLE cycle. This gives a minimum period of N+2 cycles per run.
- start held high continuously: a new run launches each time the FSM enters IDLE.
- sw_in, seq_num and mode changes during RUN/DONE have no effect. abort outside RUN is ignored.
- num holds its value between runs and changes only on entry to DONE.
- cnt is CNT_W bits. The maximum run is 2^CNT_W-1 steps, with no wrap-around hazard because seq_num==0 is handled in IDLE.

Test Plan:
- Reset: drive rst_n low mid-cycle with clk idle -> num=0, busy=0, done=0 immediately (async). Release, start with sw_in=0x08, seq_num=9, mode=0 -> busy high 9 cycles, done one cycle, num=0xC4. Intermediate lfsr values: 0x11,0x23,0x47,0x8E,0x1C,0x38,0x71,0xE2,0xC4.
- Galois: sw_in=0x08, seq_num=4, mode=1 -> busy 4 cycles, num=0xB8 (0x04,0x02,0x01,0xB8).
- Boundaries: sw_in=0x00, seq_num=1, mode=0 -> num=0x02 (seed forced to 0x01). Then sw_in=0x5A, seq_num=0 -> done one cycle after start, busy stays 0, num=0x5A.
- Abort: after num=0xC4, start sw_in=0x08, seq_num=9, assert abort on the 3rd RUN cycle -> busy falls the next cycle, done never pulses, num stays 0xC4.
- Robustness: start held high across two runs -> second run launches in the IDLE cycle after DONE. Inputs changed during RUN are ignored, so both runs give num=0xC4. Drive rst_n low on the 5th RUN cycle -> busy=0, done=0, num=0 immediately, and no done follows.
